register_file_2r1w: RTL and testbench

- General-purpose register file for the 8-bit processor datapath.
- 16 entries x 8 bits, with two independent combinational read ports and one synchronous write port.
- Read ports feed the ALU operand buses; the write port takes the writeback result.
- Every entry, including entry 0, is an ordinary writable register (no hardwired zero).

---
 rtl/register_file_2r1w_if.sv | 34 +++
 rtl/register_file_2r1w.sv | 46 ++++
 tb/tb_register_file_2r1w.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/register_file_2r1w_if.sv
// Operand-read / writeback bus of the 2-read 1-write register file.
// The datapath drives through the master modport; the register file is the slave.
interface register_file_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] read_addr0;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic [DATA_W-1:0] read_data0;
    logic [DATA_W-1:0] read_data1;

    modport master (
        output read_addr0,
        output read_addr1,
        output write_addr,
        output write_data,
        output write_enable,
        input  read_data0,
        input  read_data1
    );

    modport slave (
        input  read_addr0,
        input  read_addr1,
        input  write_addr,
        input  write_data,
        input  write_enable,
        output read_data0,
        output read_data1
    );
endinterface

// File: rtl/register_file_2r1w.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one synchronous write port.
// Optional write-first forwarding to the read ports when REGFILE_WRITE_BYPASS_EN is defined.
module register_file_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    register_file_2r1w_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [ADDR_W-1:0] rd_addr  [2];
    logic [DATA_W-1:0] rd_data  [2];

    // rst is active-low and asynchronous; it also outranks a write on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (bus.write_enable) begin
            regs_reg[bus.write_addr] <= bus.write_data;
        end
    end

    assign rd_addr[0]     = bus.read_addr0;
    assign rd_addr[1]     = bus.read_addr1;
    assign bus.read_data0 = rd_data[0];
    assign bus.read_data1 = rd_data[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read_port
`ifdef REGFILE_WRITE_BYPASS_EN
            logic hit;
            // Gating with rst keeps the outputs at zero while reset is held.
            assign hit         = rst && bus.write_enable && (rd_addr[gi] == bus.write_addr);
            assign rd_data[gi] = hit ? bus.write_data : regs_reg[rd_addr[gi]];
`else
            assign rd_data[gi] = regs_reg[rd_addr[gi]];
`endif
        end
    endgenerate
endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w: expectations are queued when reads are
// driven and popped when the combinational outputs are sampled.
module tb_register_file_2r1w;
    logic clk;
    logic rst;

    register_file_2r1w_if #(.DATA_W(8), .ADDR_W(4)) rf_if ();

    register_file_2r1w #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam logic [7:0] RDW_BEFORE = 8'h22;
`else
    localparam logic [7:0] RDW_BEFORE = 8'h11;
`endif

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        exp_t e;
        e.tag = {tag, ".p0"}; e.data = e0; exp_q.push_back(e);
        e.tag = {tag, ".p1"}; e.data = e1; exp_q.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        if (exp_q.size() < 2) begin
            check_val("scoreboard_underflow", 8'(exp_q.size()), 8'd2);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, rf_if.read_data0, e.data);
            e = exp_q.pop_front();
            check_val(e.tag, rf_if.read_data1, e.data);
            $display("rd  %s a0=%0d d0=%02h a1=%0d d1=%02h", e.tag, rf_if.read_addr0,
                     rf_if.read_data0, rf_if.read_addr1, rf_if.read_data1);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [7:0] e0, input logic [7:0] e1);
        @(negedge clk);
        rf_if.read_addr0 = a0;
        rf_if.read_addr1 = a1;
        push_exp(tag, e0, e1);
        #1;
        compare_now();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic we);
        @(negedge clk);
        rf_if.write_addr   = a;
        rf_if.write_data   = d;
        rf_if.write_enable = we;
        @(posedge clk);
        #1;
        rf_if.write_enable = 1'b0;
        $display("wr  addr=%0d data=%02h we=%0b", a, d, we);
    endtask

    initial begin
        rst                = 1'b0;
        rf_if.read_addr0   = 4'd3;
        rf_if.read_addr1   = 4'd7;
        rf_if.write_addr   = 4'd0;
        rf_if.write_data   = 8'h00;
        rf_if.write_enable = 1'b0;

        // Held reset: outputs zero regardless of address.
        push_exp("reset_hold", 8'h00, 8'h00);
        #8;
        compare_now();
        @(negedge clk);
        rst = 1'b1;

        do_write(4'd0, 8'hAA, 1'b1);
        rd("single_wr", 4'd0, 4'd1, 8'hAA, 8'h00);

        do_write(4'd1, 8'hF0, 1'b1);
        rd("dual_rd", 4'd0, 4'd1, 8'hAA, 8'hF0);
        rd("same_addr", 4'd1, 4'd1, 8'hF0, 8'hF0);

        do_write(4'd2, 8'hCC, 1'b1);
        do_write(4'd3, 8'h33, 1'b1);
        rd("b2b_wr", 4'd2, 4'd3, 8'hCC, 8'h33);
        rd("b2b_keep", 4'd0, 4'd1, 8'hAA, 8'hF0);

        do_write(4'd4, 8'h55, 1'b0);
        rd("we_low", 4'd4, 4'd4, 8'h00, 8'h00);

        // Read-during-write on register 5, both ports looking at it.
        do_write(4'd5, 8'h11, 1'b1);
        @(negedge clk);
        rf_if.read_addr0   = 4'd5;
        rf_if.read_addr1   = 4'd5;
        rf_if.write_addr   = 4'd5;
        rf_if.write_data   = 8'h22;
        rf_if.write_enable = 1'b1;
        push_exp("rdw_before", RDW_BEFORE, RDW_BEFORE);
        #1;
        compare_now();
        @(posedge clk);
        #1;
        rf_if.write_enable = 1'b0;
        push_exp("rdw_after", 8'h22, 8'h22);
        compare_now();

        // Asynchronous mid-cycle reset, with a pending write that reset must override.
        rd("pre_async", 4'd2, 4'd3, 8'hCC, 8'h33);
        @(negedge clk);
        #2;
        rf_if.write_addr   = 4'd2;
        rf_if.write_data   = 8'h77;
        rf_if.write_enable = 1'b1;
        rst = 1'b0;
        push_exp("async_rst", 8'h00, 8'h00);
        #1;
        compare_now();
        @(posedge clk);
        #1;
        push_exp("rst_prio", 8'h00, 8'h00);
        compare_now();
        @(negedge clk);
        rf_if.write_enable = 1'b0;
        rst = 1'b1;
        rd("post_rst", 4'd0, 4'd5, 8'h00, 8'h00);

        // Full sweep through both ports.
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 8'((i * 17) % 256), 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("sweep%0d", i), 4'(i), 4'(15 - i),
               8'((i * 17) % 256), 8'(((15 - i) * 17) % 256));
        end

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("sweep_rst%0d", i), 4'(i), 4'(15 - i), 8'h00, 8'h00);
        end
        rst = 1'b1;

        if (exp_q.size() != 0) begin
            check_val("scoreboard_leftover", 8'(exp_q.size()), 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
